ex_issue_ctrl: RTL and testbench
================================

// Module: ex_issue_ctrl
// PURPOSE
//  Issue/sequencing controller for the SimpleRisc EX stage. Accepts one instruction
//  per cycle from the OF/EX latch and times single- vs multi-cycle ALU ops (mul/div/mod).
//  Owns the architectural flags register (GT, EQ) and raises stall/flush for IF/OF.
//  Drives the EX/MA latch load via a valid/ready handshake.
// PARAMETERS
//  MUL_CYCLES  3   EX latency of mul (op 2); must be >=1
//  DIV_CYCLES  32  EX latency of div (op 3) and mod (op 4); must be >=1
//  CNT_W       6   counter width; 2^CNT_W >= max(MUL_CYCLES, DIV_CYCLES)
// PORTS
//  clk          in   1  clock; all state on rising edge
//  reset        in   1  async reset, active-high
//  in_valid     in   1  OF/EX latch holds a valid instruction
//  in_ready     out  1  EX accepts this cycle; accept = in_valid & in_ready
//  alu_op       in   5  AluSignal of offered instr (0 add,1 sub,2 mul,3 div,4 mod,5 cmp,6-12 other)
//  branch_taken in   1  IsBranchTaken for the offered instr (combinational from EX)
//  cmp_gt       in   1  ALU compare result op1>op2 (signed)
//  cmp_eq       in   1  ALU compare result op1==op2
//  ma_ready     in   1  EX/MA latch can take a result
//  out_valid    out  1  result valid toward EX/MA (registered)
//  mc_start     out  1  one-cycle start pulse to multi-cycle unit
//  mc_busy      out  1  multi-cycle op in progress
//  flags        out  2  {GT,EQ} architectural flags (registered)
//  stall        out  1  freeze IF/OF: in_valid & ~in_ready
//  flush        out  1  squash IF/OF: accept & branch_taken
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, out_valid=0, flags=2'b00, mc_start=0, mc_busy=0.
//  Reset mid-op: abandons the op immediately; no out_valid ever issued for it.
//  FSM states IDLE, MULTI.
//   in_ready = (state==IDLE) & (~out_valid | ma_ready).
//   IDLE, accept, single-cycle op: out_valid<=1 at that edge (latency 1); stay IDLE.
//   IDLE, accept, op 2/3/4: mc_start=1 (comb, same cycle); cnt<=LAT-1; ->MULTI.
//     LAT = MUL_CYCLES for op 2, DIV_CYCLES for ops 3/4.
//   MULTI: mc_busy=1, in_ready=0; if cnt!=0, cnt<=cnt-1; if cnt==0, out_valid<=1, ->IDLE.
//     out_valid rises exactly LAT edges after the accepting edge.
//  out_valid: set on completion; cleared at an edge with ma_ready=1 and no new completion;
//   held while ma_ready=0 (backpressure blocks the next accept via in_ready).
//  Flags: on accept with alu_op==5, flags<={cmp_gt,cmp_eq} at that edge; otherwise held.
//   An instr accepted the cycle after a cmp sees the updated flags.
//  flush: combinational, only when accept=1; branch_taken is ignored without accept.
//   Branch ops are single-cycle; flush and out_valid for the branch follow normal rules.
//  stall and flush are never both 1 (flush requires accept, stall requires ~in_ready).
//  Ops 13-31 are treated as single-cycle.
// CONFIGURATION
//  EX_PERF_CNT_EN defined: adds port stall_cycles out 32; counts clk cycles with stall=1;
//   saturates at 32'hFFFF_FFFF; reset to 0. Undefined: port and counter absent,
//   all other behaviour identical.
// TESTING
//  1 reset=1 with ma_ready=1 -> out_valid=0, flags=00, mc_busy=0; after release in_ready=1.
//  2 add (op 0) offered 1 cycle, ma_ready=1 -> accepted, out_valid=1 next cycle for 1 cycle.
//  3 div (op 3), DIV_CYCLES=32, next instr held valid -> mc_start 1 cycle, stall=1 for 32
//    cycles, out_valid 32 cycles after accept, next instr accepted the cycle out_valid rises.
//  4 cmp gt=1,eq=0 then cmp gt=0,eq=1 -> flags 2'b10 then 2'b01 on successive edges.
//  5 branch_taken=1 with accept -> flush=1 same cycle; branch_taken=1, in_valid=0 -> flush=0.
//  6 add with ma_ready=0 for 3 cycles -> out_valid held 3 cycles, in_ready=0; reset during
//    mul cycle 2 -> mc_busy=0 immediately, no out_valid afterwards.

Source files
------------

// File: rtl/ex_issue_ctrl.sv
// -----------------------------------------------------------------------------
// ex_issue_ctrl
//
// Issue and sequencing controller for the SimpleRisc EX stage.
//
// One instruction per cycle may be accepted from the OF/EX latch. The block
// decides how long each instruction stays in EX:
//   - single-cycle ops (everything except mul, div and mod) complete at the
//     edge on which they are accepted;
//   - mul (op 2) occupies EX for MUL_CYCLES cycles;
//   - div (op 3) and mod (op 4) occupy EX for DIV_CYCLES cycles.
//
// The block also holds the architectural {GT,EQ} flags, which are written by
// cmp (op 5). It raises stall and flush toward IF/OF, and it presents results
// to the EX/MA latch through a valid/ready handshake.
//
// Parameters
//   MUL_CYCLES  EX latency of mul. Must be at least 1.
//   DIV_CYCLES  EX latency of div and mod. Must be at least 1.
//   CNT_W       Width of the latency counter. 2^CNT_W must be at least
//               max(MUL_CYCLES, DIV_CYCLES).
//
// Ports
//   clk           in   1   clock; all state changes on the rising edge
//   reset         in   1   asynchronous reset, active-high
//   in_valid      in   1   OF/EX latch holds a valid instruction
//   in_ready      out  1   EX accepts this cycle (accept = in_valid & in_ready)
//   alu_op        in   5   AluSignal of the offered instruction
//   branch_taken  in   1   IsBranchTaken for the offered instruction
//   cmp_gt        in   1   ALU compare result, op1 > op2 (signed)
//   cmp_eq        in   1   ALU compare result, op1 == op2
//   ma_ready      in   1   EX/MA latch can take a result
//   out_valid     out  1   result valid toward EX/MA (registered)
//   mc_start      out  1   one-cycle start pulse to the multi-cycle unit
//   mc_busy       out  1   a multi-cycle op is in progress
//   flags         out  2   {GT,EQ} architectural flags (registered)
//   stall         out  1   freeze IF/OF
//   flush         out  1   squash IF/OF
//   stall_cycles  out  32  saturating count of stalled cycles
//                          (present only when EX_PERF_CNT_EN is defined)
//
// Build option
//   EX_PERF_CNT_EN  When defined, adds the stall_cycles port and its counter.
//                   When undefined, neither exists and all other behaviour
//                   is identical.
// -----------------------------------------------------------------------------
module ex_issue_ctrl #(
   parameter int MUL_CYCLES = 3,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  alu_op,
   input  logic        branch_taken,
   input  logic        cmp_gt,
   input  logic        cmp_eq,
   input  logic        ma_ready,
   output logic        out_valid,
   output logic        mc_start,
   output logic        mc_busy,
   output logic [1:0]  flags,
`ifdef EX_PERF_CNT_EN
   output logic [31:0] stall_cycles,
`endif
   output logic        stall,
   output logic        flush
);

   // The counter is loaded with LAT-1 so that completion lands exactly LAT
   // edges after the accepting edge: LAT edges are spent in MULTI, and the
   // count reaches 0 on the last of them.
   localparam logic [CNT_W-1:0] MUL_LAT_M1 = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAT_M1 = CNT_W'(DIV_CYCLES - 1);

   localparam logic [4:0] OP_MUL = 5'd2;
   localparam logic [4:0] OP_DIV = 5'd3;
   localparam logic [4:0] OP_MOD = 5'd4;
   localparam logic [4:0] OP_CMP = 5'd5;

   typedef enum logic {
      IDLE  = 1'b0,
      MULTI = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [1:0]       flags_q, flags_d;

   logic             accept;
   logic             is_multi;
   logic             completion;

   // Only mul, div and mod are multi-cycle. Ops 13-31 fall through to the
   // single-cycle path.
   assign is_multi = (alu_op == OP_MUL) || (alu_op == OP_DIV) || (alu_op == OP_MOD);

   // A held result blocks a new accept until EX/MA takes it. This keeps a
   // completion from overwriting an unconsumed result.
   assign in_ready = (state_q == IDLE) && (!out_valid_q || ma_ready);
   assign accept   = in_valid && in_ready;

   assign mc_start = accept && is_multi;
   assign mc_busy  = (state_q == MULTI);

   // flush needs accept and stall needs ~in_ready, so the two can never be
   // high together.
   assign stall    = in_valid && !in_ready;
   assign flush    = accept && branch_taken;

   assign out_valid = out_valid_q;
   assign flags     = flags_q;

   // Next-state and datapath control
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      completion = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_multi) begin
                  cnt_d   = (alu_op == OP_MUL) ? MUL_LAT_M1 : DIV_LAT_M1;
                  state_d = MULTI;
               end else begin
                  completion = 1'b1;
               end
            end
         end
         MULTI: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               completion = 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A new completion takes priority over draining the held result.
   always_comb begin
      out_valid_d = out_valid_q;
      if (completion) begin
         out_valid_d = 1'b1;
      end else if (ma_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Flags change only on an accepted cmp. They are visible to the very next
   // accepted instruction.
   always_comb begin
      flags_d = flags_q;
      if (accept && (alu_op == OP_CMP)) begin
         flags_d = {cmp_gt, cmp_eq};
      end
   end

   // Reset abandons any in-flight op outright. Clearing state and out_valid
   // together means the abandoned op can never report a result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         flags_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         flags_q     <= flags_d;
      end
   end

`ifdef EX_PERF_CNT_EN
   // Stalled-cycle counter. It saturates instead of wrapping, so a long run
   // never reports a deceptively small number.
   logic [31:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ex_issue_ctrl
//
// Directed testbench for ex_issue_ctrl with its default parameters
// (MUL_CYCLES=3, DIV_CYCLES=32).
//
// Inputs are driven just after each falling edge. Outputs are checked 1 time
// unit later, so both the combinational outputs for the current cycle and the
// registered state from the previous rising edge have settled.
// -----------------------------------------------------------------------------
module tb_ex_issue_ctrl;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] alu_op;
   logic       branch_taken;
   logic       cmp_gt;
   logic       cmp_eq;
   logic       ma_ready;
   logic       out_valid;
   logic       mc_start;
   logic       mc_busy;
   logic [1:0] flags;
   logic       stall;
   logic       flush;
`ifdef EX_PERF_CNT_EN
   logic [31:0] stall_cycles;
`endif

   int n_vec;
   int n_err;

   ex_issue_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .alu_op       (alu_op),
      .branch_taken (branch_taken),
      .cmp_gt       (cmp_gt),
      .cmp_eq       (cmp_eq),
      .ma_ready     (ma_ready),
      .out_valid    (out_valid),
      .mc_start     (mc_start),
      .mc_busy      (mc_busy),
      .flags        (flags),
`ifdef EX_PERF_CNT_EN
      .stall_cycles (stall_cycles),
`endif
      .stall        (stall),
      .flush        (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs after the falling edge, then let them settle.
   task automatic drive(input logic v, input logic [4:0] op, input logic br,
                        input logic gt, input logic eq, input logic mr);
      @(negedge clk);
      in_valid     = v;
      alu_op       = op;
      branch_taken = br;
      cmp_gt       = gt;
      cmp_eq       = eq;
      ma_ready     = mr;
      #1;
   endtask

   initial begin
      n_vec        = 0;
      n_err        = 0;
      reset        = 1'b1;
      in_valid     = 1'b0;
      alu_op       = 5'd0;
      branch_taken = 1'b0;
      cmp_gt       = 1'b0;
      cmp_eq       = 1'b0;
      ma_ready     = 1'b1;

      // 1: reset state, then ready once reset is released
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_flags",     32'(flags),     32'd0);
      chk("rst_mc_busy",   32'(mc_busy),   32'd0);
      chk("rst_mc_start",  32'(mc_start),  32'd0);
      reset = 1'b0;
      #1;
      chk("rel_in_ready",  32'(in_ready),  32'd1);
      chk("rel_stall",     32'(stall),     32'd0);

      // 2: add has latency 1, and out_valid lasts one cycle
      drive(1, 0, 0, 0, 0, 1);
      chk("add_in_ready",  32'(in_ready),  32'd1);
      chk("add_mc_start",  32'(mc_start),  32'd0);
      chk("add_ov_pre",    32'(out_valid), 32'd0);
      drive(0, 0, 0, 0, 0, 1);
      chk("add_ov_1",      32'(out_valid), 32'd1);
      drive(0, 0, 0, 0, 0, 1);
      chk("add_ov_2",      32'(out_valid), 32'd0);

      // Op 20 lies in the 13-31 range, so it is single-cycle.
      drive(1, 20, 0, 0, 0, 1);
      chk("op20_mc_start", 32'(mc_start),  32'd0);
      drive(0, 0, 0, 0, 0, 1);
      chk("op20_ov",       32'(out_valid), 32'd1);
      chk("op20_busy",     32'(mc_busy),   32'd0);

      // 3: div runs 32 cycles while the next instruction waits
      drive(1, 3, 0, 0, 0, 1);
      chk("div_mc_start",  32'(mc_start),  32'd1);
      chk("div_in_ready",  32'(in_ready),  32'd1);
      chk("div_stall0",    32'(stall),     32'd0);
      for (int i = 1; i <= 32; i++) begin
         drive(1, 0, 0, 0, 0, 1);
         chk($sformatf("div_stall_c%0d", i), 32'(stall),     32'd1);
         chk($sformatf("div_busy_c%0d", i),  32'(mc_busy),   32'd1);
         chk($sformatf("div_ov_c%0d", i),    32'(out_valid), 32'd0);
         chk($sformatf("div_mcs_c%0d", i),   32'(mc_start),  32'd0);
      end
      drive(1, 0, 0, 0, 0, 1);
      chk("div_done_ov",       32'(out_valid), 32'd1);
      chk("div_done_busy",     32'(mc_busy),   32'd0);
      chk("div_next_in_ready", 32'(in_ready),  32'd1);
      chk("div_next_stall",    32'(stall),     32'd0);
      drive(0, 0, 0, 0, 0, 1);
      chk("div_next_ov",       32'(out_valid), 32'd1);
      drive(0, 0, 0, 0, 0, 1);
      chk("div_next_ov_clr",   32'(out_valid), 32'd0);

      // 4: two back-to-back cmp instructions update the flags
      drive(1, 5, 0, 1, 0, 1);
      chk("cmp1_flags_pre", 32'(flags), 32'b00);
      drive(1, 5, 0, 0, 1, 1);
      chk("cmp1_flags",     32'(flags), 32'b10);
      drive(0, 5, 0, 1, 1, 1);
      chk("cmp2_flags",     32'(flags), 32'b01);
      drive(1, 0, 0, 1, 1, 1);
      chk("flags_hold",     32'(flags), 32'b01);

      // 5: flush only when the branch is actually accepted
      drive(1, 6, 1, 0, 0, 1);
      chk("br_flush",    32'(flush),    32'd1);
      chk("br_in_ready", 32'(in_ready), 32'd1);
      chk("br_stall",    32'(stall),    32'd0);
      drive(0, 6, 1, 0, 0, 1);
      chk("br_noacc_flush", 32'(flush),     32'd0);
      chk("br_ov",          32'(out_valid), 32'd1);
      drive(0, 0, 0, 0, 0, 1);
      chk("br_ov_clr",      32'(out_valid), 32'd0);

      // 6a: backpressure holds the add result and blocks the next accept
      drive(1, 0, 0, 0, 0, 0);
      chk("bp_accept", 32'(in_ready), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         drive(1, 0, 0, 0, 0, 0);
         chk($sformatf("bp_ov_c%0d", i),    32'(out_valid), 32'd1);
         chk($sformatf("bp_rdy_c%0d", i),   32'(in_ready),  32'd0);
         chk($sformatf("bp_stall_c%0d", i), 32'(stall),     32'd1);
      end
      drive(0, 0, 0, 0, 0, 1);
      chk("bp_release_ov",  32'(out_valid), 32'd1);
      chk("bp_release_rdy", 32'(in_ready),  32'd1);
      drive(0, 0, 0, 0, 0, 1);
      chk("bp_drain_ov",    32'(out_valid), 32'd0);

      // 6b: reset during the second cycle of a mul abandons it
      drive(1, 2, 1, 0, 0, 1);
      chk("mul_mc_start", 32'(mc_start), 32'd1);
      chk("mul_flush",    32'(flush),    32'd1);
      drive(1, 0, 1, 0, 0, 1);
      chk("mul_c1_busy",  32'(mc_busy),  32'd1);
      chk("mul_c1_stall", 32'(stall),    32'd1);
      chk("mul_c1_flush", 32'(flush),    32'd0);
      drive(0, 0, 0, 0, 0, 1);
      chk("mul_c2_busy",  32'(mc_busy),  32'd1);
      #1;
      reset = 1'b1;
      #1;
      chk("mul_rst_busy",  32'(mc_busy),   32'd0);
      chk("mul_rst_ov",    32'(out_valid), 32'd0);
      chk("mul_rst_flags", 32'(flags),     32'b00);
      drive(0, 0, 0, 0, 0, 1);
      reset = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         drive(0, 0, 0, 0, 0, 1);
         chk($sformatf("mul_post_ov_c%0d", i),   32'(out_valid), 32'd0);
         chk($sformatf("mul_post_busy_c%0d", i), 32'(mc_busy),   32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
